timer_core_mc: RTL and testbench

Multi-channel successor to the single-compare timer register block. It combines an APB-facing register file with a 64-bit free-running counter, a power-of-two prescaler, NUM_CH independent 64-bit compare channels with per-channel sticky RW1C status and enables, a debug-halt handshake, and a tear-free 64-bit counter read. It sits behind the APB slave bridge and drives the per-channel and combined interrupt lines to the interrupt controller.

---
 rtl/timer_core_mc.sv | 178 +++++++++++++++++
 tb/tb_timer_core_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : timer_core_mc
// Description : APB register block with a 64-bit prescaled counter, NUM_CH
//               compare channels with sticky RW1C status, debug halt
//               handshake and a tear-free 64-bit counter read.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_core_mc #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  dbg_mode,
    output logic [NUM_CH-1:0]     irq,
    output logic                  irq_any
);

    localparam logic [31:0] c_A_TCR   = 32'h000;
    localparam logic [31:0] c_A_TDR0  = 32'h004;
    localparam logic [31:0] c_A_TDR1  = 32'h008;
    localparam logic [31:0] c_A_THCSR = 32'h00C;
    localparam logic [31:0] c_A_TIER  = 32'h010;
    localparam logic [31:0] c_A_TISR  = 32'h014;

    logic                   r_timer_en;
    logic                   r_div_en;
    logic [3:0]             r_div_val;
    logic [7:0]             r_presc;
    logic [63:0]            r_cnt;
    logic [31:0]            r_shadow;
    logic                   r_halt_req;
    logic                   r_halt_ack;
    logic [NUM_CH-1:0]      r_int_en;
    logic [NUM_CH-1:0]      r_int_st;
    logic [NUM_CH-1:0][31:0] r_cmp_lo;
    logic [NUM_CH-1:0][31:0] r_cmp_hi;

    logic [31:0]       w_addr32;
    logic              w_wr_tcr, w_wr_tdr0, w_wr_tdr1, w_wr_thcsr, w_wr_tier, w_wr_tisr;
    logic              w_rd_tdr0;
    logic              w_tcr_acc;
    logic              w_stop;
    logic              w_in_cmp;
    logic [2:0]        w_ch;
    logic              w_halted;
    logic              w_run;
    logic              w_tick;
    logic [7:0]        w_div_lim;
    logic [NUM_CH-1:0] w_match;
    logic [NUM_CH-1:0] w_clr;
    logic [31:0]       w_rd_val;

    assign w_addr32   = 32'(addr);
    assign w_wr_tcr   = wr_en && (w_addr32 == c_A_TCR);
    assign w_wr_tdr0  = wr_en && (w_addr32 == c_A_TDR0);
    assign w_wr_tdr1  = wr_en && (w_addr32 == c_A_TDR1);
    assign w_wr_thcsr = wr_en && (w_addr32 == c_A_THCSR);
    assign w_wr_tier  = wr_en && (w_addr32 == c_A_TIER);
    assign w_wr_tisr  = wr_en && (w_addr32 == c_A_TISR);
    assign w_rd_tdr0  = rd_en && (w_addr32 == c_A_TDR0);

    // Divider settings above 8 would overflow the 8-bit prescaler; drop the whole write.
    assign w_tcr_acc = w_wr_tcr && (wdata[11:8] <= 4'd8);
    assign w_stop    = w_tcr_acc && r_timer_en && !wdata[0];

    assign w_ch     = w_addr32[5:3];
    assign w_in_cmp = (w_addr32[31:6] == 26'h4) && (w_addr32[1:0] == 2'b00) &&
                      (32'(w_ch) < 32'(NUM_CH));

    assign w_halted  = r_halt_req && dbg_mode;
    assign w_run     = r_timer_en && !w_halted;
    assign w_div_lim = 8'((9'd1 << r_div_val) - 9'd1);
    assign w_tick    = !r_div_en || (r_presc == w_div_lim);
    assign w_clr     = w_wr_tisr ? wdata[NUM_CH-1:0] : '0;

    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_match[k] = (r_cnt == {r_cmp_hi[k], r_cmp_lo[k]});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_en <= 1'b0;
            r_div_en   <= 1'b0;
            r_div_val  <= 4'd1;
            r_halt_req <= 1'b0;
            r_halt_ack <= 1'b0;
            r_int_en   <= '0;
            r_int_st   <= '0;
            r_shadow   <= '0;
        end else begin
            if (w_tcr_acc) begin
                r_timer_en <= wdata[0];
                r_div_en   <= wdata[1];
                r_div_val  <= wdata[11:8];
            end
            if (w_wr_thcsr) r_halt_req <= wdata[0];
            if (w_wr_tier)  r_int_en   <= wdata[NUM_CH-1:0];
            if (w_rd_tdr0)  r_shadow   <= r_cnt[63:32];
            r_halt_ack <= w_halted;
            // Set dominates a same-cycle clear.
            r_int_st   <= (r_int_st & ~w_clr) | w_match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tcr_acc) begin
            r_presc <= '0;
        end else if (w_run && r_div_en) begin
            r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_stop) begin
            r_cnt <= '0;
        end else if (w_wr_tdr0) begin
            r_cnt[31:0] <= wdata;
        end else if (w_wr_tdr1) begin
            r_cnt[63:32] <= wdata;
        end else if (w_run && w_tick) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_lo <= '1;
            r_cmp_hi <= '1;
        end else if (wr_en && w_in_cmp) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_ch == 3'(k)) begin
                    if (w_addr32[2]) r_cmp_hi[k] <= wdata;
                    else             r_cmp_lo[k] <= wdata;
                end
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (w_addr32)
            c_A_TCR:   w_rd_val = {20'b0, r_div_val, 6'b0, r_div_en, r_timer_en};
            c_A_TDR0:  w_rd_val = r_cnt[31:0];
            c_A_TDR1:  w_rd_val = r_shadow;
            c_A_THCSR: w_rd_val = {30'b0, r_halt_ack, r_halt_req};
            c_A_TIER:  w_rd_val = 32'(r_int_en);
            c_A_TISR:  w_rd_val = 32'(r_int_st);
            default: begin
                if (w_in_cmp) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (w_ch == 3'(k)) w_rd_val = w_addr32[2] ? r_cmp_hi[k] : r_cmp_lo[k];
                    end
                end
            end
        endcase
    end

    assign rdata   = rd_en ? w_rd_val : '0;
    assign irq     = r_int_st & r_int_en;
    assign irq_any = |irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_core_mc
// Description : Self-checking bench for timer_core_mc (register table plus
//               directed prescaler, compare, wrap and halt sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_core_mc;

    localparam int NUM_CH = 4;

    localparam logic [11:0] c_TCR   = 12'h000;
    localparam logic [11:0] c_TDR0  = 12'h004;
    localparam logic [11:0] c_TDR1  = 12'h008;
    localparam logic [11:0] c_THCSR = 12'h00C;
    localparam logic [11:0] c_TIER  = 12'h010;
    localparam logic [11:0] c_TISR  = 12'h014;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       addr = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              dbg_mode = 1'b0;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    timer_core_mc #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(NUM_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .dbg_mode (dbg_mode),
        .irq      (irq),
        .irq_any  (irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];
    string       sb_n[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic sb_push(input logic [31:0] e, input string n);
        sb_q.push_back(e);
        sb_n.push_back(n);
    endtask

    task automatic sb_check(input logic [31:0] act);
        logic [31:0] e;
        string       n;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0x%08h with nothing expected", act);
        end else begin
            e = sb_q.pop_front();
            n = sb_n.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        addr  = a;
        rd_en = 1'b1;
        #2;
        v = rdata;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] e, input string n);
        logic [31:0] v;
        sb_push(e, n);
        rd(a, v);
        sb_check(v);
    endtask

    task automatic chk_irq(input logic [NUM_CH-1:0] e, input string n);
        sb_push({27'b0, |e, e}, n);
        sb_check({27'b0, irq_any, irq});
    endtask

    task automatic run_reset_table();
        for (int i = 0; i < tbl.size(); i++) begin
            rd_chk(tbl[i].a, tbl[i].exp, tbl[i].name);
        end
        chk_irq('0, "reset_irq");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, v;

        tbl.push_back('{c_TCR,   32'h0000_0100, "rst_tcr"});
        tbl.push_back('{c_TDR0,  32'h0,         "rst_tdr0"});
        tbl.push_back('{c_TDR1,  32'h0,         "rst_tdr1"});
        tbl.push_back('{c_THCSR, 32'h0,         "rst_thcsr"});
        tbl.push_back('{c_TIER,  32'h0,         "rst_tier"});
        tbl.push_back('{c_TISR,  32'h0,         "rst_tisr"});
        for (int k = 0; k < NUM_CH; k++) begin
            tbl.push_back('{12'(12'h100 + 8 * k), 32'hFFFF_FFFF, $sformatf("rst_tcmp%0d_lo", k)});
            tbl.push_back('{12'(12'h104 + 8 * k), 32'hFFFF_FFFF, $sformatf("rst_tcmp%0d_hi", k)});
        end
        tbl.push_back('{12'h200, 32'h0, "unmapped_200"});
        tbl.push_back('{12'h120, 32'h0, "unmapped_ch4"});

        repeat (3) cyc();
        rst = 1'b0;
        addr = c_TCR;
        #2;
        sb_push(32'h0, "rdata_idle");
        sb_check(rdata);
        cyc();
        run_reset_table();

        // Prescaled count: one increment per four cycles.
        wr(c_TCR, 32'h0000_0203);
        repeat (40) cyc();
        rd(c_TDR0, v);
        n_checks++;
        if (v < 32'd9 || v > 32'd11) begin
            n_fail++;
            $display("FAIL presc_count: got %0d expected 10 +/- 1", v);
        end
        rd(c_TDR0, a);
        repeat (3) cyc();
        rd(c_TDR0, b);
        sb_push(a + 32'd1, "presc_step");
        sb_check(b);
        wr(c_TCR, 32'h0000_0903);
        rd_chk(c_TCR, 32'h0000_0203, "tcr_divval9_ignored");
        wr(c_TCR, 32'h0000_0803);
        rd_chk(c_TCR, 32'h0000_0803, "tcr_divval8_ok");

        // Compare on channel 2.
        wr(c_TCR, 32'h0);
        wr(12'h110, 32'h20);
        wr(12'h114, 32'h0);
        wr(c_TIER, 32'h4);
        wr(c_TCR, 32'h1);
        repeat (32) cyc();
        chk_irq('0, "irq_before_match");
        rd_chk(c_TDR0, 32'h20, "cnt_at_cmp2");
        chk_irq(4'b0100, "irq2_after_match");
        wr(c_TISR, 32'h0);
        rd_chk(c_TISR, 32'h4, "tisr_write0_noop");
        wr(c_TISR, 32'h4);
        rd_chk(c_TISR, 32'h0, "tisr_w1c");
        chk_irq('0, "irq_cleared");

        // Set/clear collision on channel 0 with the counter held at TCMP0.
        wr(c_TCR, 32'h0);
        wr(12'h100, 32'h0);
        wr(12'h104, 32'h0);
        wr(c_TISR, 32'h1);
        rd_chk(c_TISR, 32'h1, "tisr_set_wins");
        chk_irq('0, "irq_masked_by_tier");
        wr(12'h104, 32'hFFFF_FFFF);
        wr(c_TISR, 32'h1);
        rd_chk(c_TISR, 32'h0, "tisr_clear_after_collision");

        // Carry across the halves and the shadowed high read.
        wr(c_TCR, 32'h1);
        wr(c_TDR1, 32'h0);
        wr(c_TDR0, 32'hFFFF_FFFE);
        cyc();
        rd_chk(c_TDR0, 32'hFFFF_FFFF, "atomic_lo");
        rd_chk(c_TDR1, 32'h0,         "atomic_hi_shadow");
        rd_chk(c_TDR0, 32'h1,         "carry_lo");
        rd_chk(c_TDR1, 32'h1,         "carry_hi");

        // Full wrap to zero; the all-ones default compares of ch1/ch3 fire.
        wr(c_TDR1, 32'hFFFF_FFFF);
        wr(c_TDR0, 32'hFFFF_FFFF);
        rd_chk(c_TDR0, 32'hFFFF_FFFF, "max_lo");
        rd_chk(c_TDR1, 32'hFFFF_FFFF, "max_hi");
        rd_chk(c_TDR0, 32'h1,         "wrap_lo");
        rd_chk(c_TDR1, 32'h0,         "wrap_hi");
        rd_chk(c_TISR, 32'hA,         "tisr_allones_match");

        // Debug halt handshake.
        wr(c_TCR, 32'h0);
        wr(c_TCR, 32'h1);
        wr(c_THCSR, 32'h1);
        rd_chk(c_THCSR, 32'h1, "halt_req_no_dbg");
        rd(c_TDR0, a);
        rd(c_TDR0, b);
        sb_push(a + 32'd1, "run_no_dbg");
        sb_check(b);
        rd(c_TDR0, a);
        dbg_mode = 1'b1;
        rd_chk(c_THCSR, 32'h1, "ack_not_yet");
        rd_chk(c_TDR0, a + 32'd1, "freeze");
        rd_chk(c_THCSR, 32'h3, "ack_rises");
        rd_chk(c_TDR0, a + 32'd1, "frozen");
        dbg_mode = 1'b0;
        rd_chk(c_THCSR, 32'h3, "ack_holds");
        rd_chk(c_THCSR, 32'h1, "ack_falls");
        rd_chk(c_TDR0, a + 32'd3, "resume");

        // Reset while halted.
        dbg_mode = 1'b1;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dbg_mode = 1'b0;
        run_reset_table();

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
